// File: rtl/zeroriscy_defines.sv
// Shared PPU types: opcode encoding, controller FSM states and default abort limit.
package zeroriscy_defines;

  localparam int unsigned TIMEOUT_DEFAULT = 64;
  localparam int unsigned PPU_OP_W        = 3;
  localparam int unsigned WD_CNT_W        = 8;

  typedef enum logic [PPU_OP_W-1:0] {
    PPU_ADD     = 3'd0,
    PPU_SUB     = 3'd1,
    PPU_MUL     = 3'd2,
    PPU_DIV     = 3'd3,
    PPU_FMADD_S = 3'd4,
    PPU_FMADD_C = 3'd5,
    PPU_F2P     = 3'd6,
    PPU_P2F     = 3'd7
  } ppu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } ppu_state_e;

endpackage

// File: rtl/zeroriscy_ppu_watchdog.sv
// Cycle counter bounding the time spent waiting on the PPU datapath.
module zeroriscy_ppu_watchdog
  import zeroriscy_defines::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_c
);

  logic [WD_CNT_W-1:0] cnt_q;
  logic [WD_CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expire_c) begin
      cnt_d = cnt_q + WD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_c = (cnt_q == WD_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/zeroriscy_ppu_ctrl.sv
// PPU request sequencer: latches a decoder request, issues it to the datapath,
// waits for completion with a timeout, and handles pipeline flushes.
module zeroriscy_ppu_ctrl
  import zeroriscy_defines::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_i,
  input  logic [PPU_OP_W-1:0] op_i,
  input  logic [WIDTH-1:0]    operand_a_i,
  input  logic [WIDTH-1:0]    operand_b_i,
  input  logic [WIDTH-1:0]    operand_c_i,
  input  logic                flush_i,
  output logic                ready_o,
  output logic [WIDTH-1:0]    result_o,
  output logic                result_valid_o,
  output logic                timeout_o,
  output logic                busy_o,
  output logic                ppu_valid_o,
  input  logic                ppu_ready_i,
  output logic [PPU_OP_W-1:0] ppu_op_o,
  output logic [WIDTH-1:0]    ppu_a_o,
  output logic [WIDTH-1:0]    ppu_b_o,
  output logic [WIDTH-1:0]    ppu_c_o,
  input  logic                ppu_done_i,
  input  logic [WIDTH-1:0]    ppu_result_i
);

  ppu_state_e       state_q, state_d;
  ppu_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             result_valid_c, timeout_c;
  logic             wd_clear_c, wd_enable_c, wd_expire_c;

  zeroriscy_ppu_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (wd_clear_c),
    .enable_i (wd_enable_c),
    .expire_c (wd_expire_c)
  );

  always_comb begin
    state_d        = state_q;
    op_d           = op_q;
    a_d            = a_q;
    b_d            = b_q;
    c_d            = c_q;
    result_d       = result_q;
    result_valid_c = 1'b0;
    timeout_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (en_i && !flush_i) begin
          op_d    = ppu_op_e'(op_i);
          a_d     = operand_a_i;
          b_d     = operand_b_i;
          c_d     = operand_c_i;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (ppu_ready_i) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A flush coinciding with done consumes the completion, so no drain is needed.
        if (flush_i) begin
          state_d = ppu_done_i ? ST_IDLE : ST_DRAIN;
        end else if (ppu_done_i) begin
          result_d = ppu_result_i;
          state_d  = ST_DONE;
        end else if (wd_expire_c) begin
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_DONE: begin
        result_valid_c = !flush_i;
        state_d        = ST_IDLE;
      end
      ST_DRAIN: begin
        if (ppu_done_i) begin
          state_d = ST_IDLE;
        end else if (wd_expire_c) begin
          timeout_c = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d     = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    valid_d     = (state_d == ST_ISSUE);
    // Every state change restarts the count, so WAIT and DRAIN each get a full budget.
    wd_clear_c  = (state_d != state_q);
    wd_enable_c = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= PPU_ADD;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      result_q <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign ready_o        = ready_q;
  assign busy_o         = busy_q;
  assign ppu_valid_o    = valid_q;
  assign ppu_op_o       = op_q;
  assign ppu_a_o        = a_q;
  assign ppu_b_o        = b_q;
  assign ppu_c_o        = c_q;
  assign result_o       = result_q;
  // Strobes are decided in the cycle they occur so a same-cycle flush can still veto them.
  assign result_valid_o = result_valid_c;
  assign timeout_o      = timeout_c;

endmodule

// File: tb/tb_zeroriscy_ppu_ctrl.sv
// Directed bench for zeroriscy_ppu_ctrl: issue, stall, timeout, flush and reset cases.
module tb_zeroriscy_ppu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i, flush_i, ppu_ready_i, ppu_done_i;
  logic [2:0]  op_i;
  logic [31:0] operand_a_i, operand_b_i, operand_c_i, ppu_result_i;
  logic        ready_o, result_valid_o, timeout_o, busy_o, ppu_valid_o;
  logic [2:0]  ppu_op_o;
  logic [31:0] result_o, ppu_a_o, ppu_b_o, ppu_c_o;

  int n_tests = 0;
  int n_fail  = 0;

  zeroriscy_ppu_ctrl #(.WIDTH(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .op_i(op_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i), .operand_c_i(operand_c_i),
    .flush_i(flush_i), .ready_o(ready_o), .result_o(result_o),
    .result_valid_o(result_valid_o), .timeout_o(timeout_o), .busy_o(busy_o),
    .ppu_valid_o(ppu_valid_o), .ppu_ready_i(ppu_ready_i), .ppu_op_o(ppu_op_o),
    .ppu_a_o(ppu_a_o), .ppu_b_o(ppu_b_o), .ppu_c_o(ppu_c_o),
    .ppu_done_i(ppu_done_i), .ppu_result_i(ppu_result_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    en_i = 1'b0; flush_i = 1'b0; ppu_ready_i = 1'b0; ppu_done_i = 1'b0;
  endtask

  // Drive a request in IDLE; returns at the first ISSUE cycle with strobes quiet.
  task automatic request(input logic [2:0] op, input logic [31:0] a, b, c);
    quiet();
    en_i = 1'b1; op_i = op; operand_a_i = a; operand_b_i = b; operand_c_i = c;
    #1 chk("req_ready", 32'(ready_o), 32'd1);
    @(negedge clk);
    quiet();
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1; quiet(); op_i = 3'd0;
    operand_a_i = '0; operand_b_i = '0; operand_c_i = '0; ppu_result_i = '0;
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_valid", 32'(ppu_valid_o), 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_a", ppu_a_o, 32'd0);
    chk("rst_strobes", {30'd0, result_valid_o, timeout_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ADD issued with immediate ready, done three cycles after handshake
    request(3'd0, 32'h4000_0000, 32'h4000_0000, 32'h0);
    ppu_ready_i = 1'b1;
    #1 chk("add_valid", 32'(ppu_valid_o), 32'd1);
    chk("add_a", ppu_a_o, 32'h4000_0000);
    chk("add_op", 32'(ppu_op_o), 32'd0);
    chk("add_ready_lo", 32'(ready_o), 32'd0);
    @(negedge clk); quiet();
    #1 chk("add_wait_valid", 32'(ppu_valid_o), 32'd0);
    chk("add_wait_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    #1 chk("add_wait2_rv", 32'(result_valid_o), 32'd0);
    @(negedge clk);
    ppu_done_i = 1'b1; ppu_result_i = 32'h8000_0000;
    #1 chk("add_done_rv", 32'(result_valid_o), 32'd0);
    @(negedge clk); quiet(); ppu_result_i = 32'hDEAD_BEEF;
    #1 chk("add_strobe", 32'(result_valid_o), 32'd1);
    chk("add_result", result_o, 32'h8000_0000);
    chk("add_done_ready", 32'(ready_o), 32'd0);
    @(negedge clk);
    #1 chk("add_after_rv", 32'(result_valid_o), 32'd0);
    chk("add_after_ready", 32'(ready_o), 32'd1);
    chk("add_hold", result_o, 32'h8000_0000);

    // SUB with ppu_ready_i low for five cycles
    request(3'd1, 32'h1234_5678, 32'h1, 32'h2);
    for (int i = 0; i < 5; i++) begin
      #1 chk("stall_valid", 32'(ppu_valid_o), 32'd1);
      chk("stall_a", ppu_a_o, 32'h1234_5678);
      @(negedge clk);
    end
    ppu_ready_i = 1'b1;
    #1 chk("stall_hs_valid", 32'(ppu_valid_o), 32'd1);
    chk("stall_c", ppu_c_o, 32'h2);
    @(negedge clk); quiet();
    ppu_done_i = 1'b1; ppu_result_i = 32'h0000_0055;
    #1 chk("stall_wait_valid", 32'(ppu_valid_o), 32'd0);
    chk("stall_wait_busy", 32'(busy_o), 32'd1);
    @(negedge clk); quiet();
    #1 chk("stall_strobe", 32'(result_valid_o), 32'd1);
    chk("stall_result", result_o, 32'h55);
    @(negedge clk);

    // MUL with no done: abort on WAIT cycle 8
    request(3'd2, 32'h3, 32'h4, 32'h0);
    ppu_ready_i = 1'b1;
    @(negedge clk); quiet();
    for (int w = 1; w <= 8; w++) begin
      #1 chk("to_pulse", 32'(timeout_o), (w == 8) ? 32'd1 : 32'd0);
      chk("to_rv", 32'(result_valid_o), 32'd0);
      @(negedge clk);
    end
    #1 chk("to_ready", 32'(ready_o), 32'd1);
    chk("to_busy", 32'(busy_o), 32'd0);
    chk("to_pulse_end", 32'(timeout_o), 32'd0);

    // Flush in WAIT, done two cycles later while draining
    @(negedge clk);
    request(3'd3, 32'h9, 32'h3, 32'h0);
    ppu_ready_i = 1'b1;
    @(negedge clk); quiet();
    flush_i = 1'b1;
    @(negedge clk); quiet();
    #1 chk("drain_busy", 32'(busy_o), 32'd1);
    chk("drain_ready", 32'(ready_o), 32'd0);
    @(negedge clk);
    ppu_done_i = 1'b1; ppu_result_i = 32'h0000_0BAD;
    #1 chk("drain_done_rv", 32'(result_valid_o), 32'd0);
    @(negedge clk); quiet();
    #1 chk("drain_idle_busy", 32'(busy_o), 32'd0);
    chk("drain_rv", 32'(result_valid_o), 32'd0);
    chk("drain_result_kept", result_o, 32'h55);

    // Flush and done together in WAIT
    request(3'd4, 32'h1, 32'h2, 32'h3);
    ppu_ready_i = 1'b1;
    @(negedge clk); quiet();
    flush_i = 1'b1; ppu_done_i = 1'b1; ppu_result_i = 32'h77;
    #1 chk("fd_rv", 32'(result_valid_o), 32'd0);
    @(negedge clk); quiet();
    #1 chk("fd_ready", 32'(ready_o), 32'd1);
    chk("fd_busy", 32'(busy_o), 32'd0);
    chk("fd_result_kept", result_o, 32'h55);

    // Flush with en in IDLE drops the request
    en_i = 1'b1; flush_i = 1'b1; op_i = 3'd6;
    @(negedge clk); quiet();
    #1 chk("idle_flush_busy", 32'(busy_o), 32'd0);
    chk("idle_flush_valid", 32'(ppu_valid_o), 32'd0);

    // Flush in ISSUE returns to IDLE without handshake
    request(3'd6, 32'hCAFE, 32'h0, 32'h0);
    flush_i = 1'b1;
    #1 chk("iss_flush_valid_cur", 32'(ppu_valid_o), 32'd1);
    @(negedge clk); quiet();
    #1 chk("iss_flush_valid", 32'(ppu_valid_o), 32'd0);
    chk("iss_flush_ready", 32'(ready_o), 32'd1);

    // FMADD_C completes, then flush during DONE vetoes the strobe
    request(3'd5, 32'h10, 32'h20, 32'h30);
    #1 chk("fmc_op", 32'(ppu_op_o), 32'd5);
    ppu_ready_i = 1'b1;
    @(negedge clk); quiet();
    ppu_done_i = 1'b1; ppu_result_i = 32'h99;
    @(negedge clk); quiet();
    flush_i = 1'b1;
    #1 chk("done_flush_rv", 32'(result_valid_o), 32'd0);
    chk("done_flush_result", result_o, 32'h99);
    @(negedge clk); quiet();
    #1 chk("done_flush_ready", 32'(ready_o), 32'd1);

    // Done while IDLE is ignored
    ppu_done_i = 1'b1; ppu_result_i = 32'h1111;
    @(negedge clk); quiet();
    #1 chk("idle_done_busy", 32'(busy_o), 32'd0);
    chk("idle_done_result", result_o, 32'h99);
    chk("idle_done_rv", 32'(result_valid_o), 32'd0);

    // DRAIN times out when done never arrives
    request(3'd0, 32'h5, 32'h6, 32'h0);
    ppu_ready_i = 1'b1;
    @(negedge clk); quiet();
    flush_i = 1'b1;
    @(negedge clk); quiet();
    for (int d = 1; d <= 8; d++) begin
      #1 chk("drain_to_pulse", 32'(timeout_o), (d == 8) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
    #1 chk("drain_to_ready", 32'(ready_o), 32'd1);

    // Asynchronous reset while in ISSUE
    request(3'd7, 32'hAAAA, 32'h0, 32'h0);
    #1 chk("rst_iss_valid_pre", 32'(ppu_valid_o), 32'd1);
    chk("rst_iss_op_pre", 32'(ppu_op_o), 32'd7);
    #1 rst = 1'b1;
    #1 chk("rst_iss_valid", 32'(ppu_valid_o), 32'd0);
    chk("rst_iss_ready", 32'(ready_o), 32'd1);
    chk("rst_iss_a", ppu_a_o, 32'd0);
    chk("rst_iss_result", result_o, 32'd0);
    chk("rst_iss_strobes", {30'd0, result_valid_o, timeout_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("post_rst_busy", 32'(busy_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/zeroriscy_ppu_ctrl.md
ZERORISCY_PPU_CTRL -- requirements
Module: zeroriscy_ppu_ctrl

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width.
REQ-002 Parameter TIMEOUT, default 64: maximum cycles in WAIT or DRAIN before abort; legal range is 2..255.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 en_i  in  1  decoder PPU request valid.
REQ-006 op_i  in  3  ppu_op_e: ADD=0, SUB=1, MUL=2, DIV=3, FMADD_S=4, FMADD_C=5, F2P=6, P2F=7.
REQ-007 operand_a_i / operand_b_i / operand_c_i  in  WIDTH each  source operands.
REQ-008 flush_i  in  1  pipeline kill.
REQ-009 ready_o  out  1  request accepted when en_i&&ready_o.
REQ-010 result_o  out  WIDTH  writeback data.
REQ-011 result_valid_o  out  1  one-cycle writeback strobe.
REQ-012 timeout_o  out  1  one-cycle abort strobe.
REQ-013 busy_o  out  1  state!=IDLE.
REQ-014 ppu_valid_o  out  1 / ppu_ready_i  in  1  issue handshake to the datapath.
REQ-015 ppu_op_o  out  3 / ppu_a_o, ppu_b_o, ppu_c_o  out  WIDTH  latched command.
REQ-016 ppu_done_i  in  1 / ppu_result_i  in  WIDTH  datapath completion and result.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, DONE, DRAIN.
REQ-018 IDLE: ready_o=1; en_i&&!flush_i latches op and operands, next state ISSUE.
REQ-019 ISSUE: ppu_valid_o=1 with stable op/operands until ppu_ready_i; on the handshake cycle, next state WAIT and clear the counter.
REQ-020 WAIT: the counter increments each cycle; ppu_done_i captures ppu_result_i and the next state is DONE.
REQ-021 DONE: result_valid_o=1 for exactly one cycle with result_o=captured value; next state IDLE.
REQ-022 ready_o SHALL be 0 in every state except IDLE, so the issue-to-issue minimum is 4 cycles.
REQ-023 Minimum latency SHALL be: accept at cycle 0, ISSUE at cycle 1, WAIT at cycle 2; done at cycle k gives result_valid_o at cycle k+1.
REQ-024 Timeout: if the counter reaches TIMEOUT-1 in WAIT with no done, timeout_o=1 for one cycle, result_valid_o stays 0, next state IDLE.
REQ-025 flush_i in ISSUE SHALL drop ppu_valid_o in the next cycle and go to IDLE without a handshake.
REQ-026 flush_i in WAIT SHALL go to DRAIN; DRAIN ignores ppu_result_i and goes to IDLE on ppu_done_i or on the timeout (timeout_o=1).
REQ-027 flush_i in DONE SHALL suppress result_valid_o; next state IDLE.
REQ-028 flush_i together with ppu_done_i in WAIT: flush wins, the result is discarded, done is consumed, next state IDLE.
REQ-029 flush_i together with en_i in IDLE: the request is dropped and the state stays IDLE.
REQ-030 ppu_done_i outside WAIT/DRAIN SHALL be ignored.
REQ-031 result_o SHALL hold its last captured value between strobes.
REQ-032 FMADD_S and FMADD_C SHALL be sequenced identically to the other ops; the accumulator state is owned by the datapath.

Reset
REQ-033 rst SHALL force state=IDLE, counter=0, all outputs 0 except ready_o=1, and all latched operands/result=0, independent of clk.
REQ-034 Reset mid-operation SHALL abandon the op without asserting result_valid_o or timeout_o.

Structure
REQ-035 ppu_op_e, the FSM state enum and TIMEOUT_DEFAULT SHALL reside in zeroriscy_defines.
REQ-036 The timeout counter SHALL be sub-module zeroriscy_ppu_watchdog (clear, enable, expire).

Verification
REQ-037 ADD 0x4000_0000+0x4000_0000, ppu_ready_i=1, done 3 cycles after the handshake -> result_valid_o exactly 1 cycle later, result_o=ppu_result_i.
REQ-038 ppu_ready_i held low 5 cycles -> ppu_valid_o and ppu_a_o stable for all 5 cycles, WAIT entered on the 6th.
REQ-039 TIMEOUT=8, no done -> timeout_o pulses on WAIT cycle 8, no result_valid_o, ready_o=1 on the next cycle.
REQ-040 flush_i in WAIT, done 2 cycles later -> no result_valid_o, busy_o=0 one cycle after done.
REQ-041 flush_i and ppu_done_i in the same WAIT cycle -> no strobe, IDLE next cycle.
REQ-042 rst asserted in ISSUE asynchronously -> ppu_valid_o=0 immediately, ready_o=1.
